// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl: error counting and reload-based recovery for a hamming_register (optional corrCnt counter via HAMMING_SCRUB_CORR_CNT_EN)
module hamming_scrub_ctrl #(
  parameter int p_dataSize      = 5,
  parameter int p_errCntWidth   = 8,
  parameter int p_reloadTimeout = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regCorrErr,
  input  logic                     regUncorrErr,
  input  logic                     hostWE,
  input  logic [p_dataSize-1:0]    hostData,
  input  logic                     reloadAck,
  input  logic [p_dataSize-1:0]    reloadData,
  input  logic                     clrCnt,
  output logic                     regWE,
  output logic [p_dataSize-1:0]    regWData,
  output logic                     reloadReq,
  output logic                     busy,
  output logic                     fatal,
  output logic [p_errCntWidth-1:0] corrCnt,
  output logic [p_errCntWidth-1:0] uncorrCnt
);
  localparam int TW = $clog2(p_reloadTimeout + 1);
  typedef enum logic [2:0] {IDLE, REQ, WRITE, SETTLE, FAIL} state_t;
  state_t                  state, next;
  logic [TW-1:0]           tcnt;
  logic [p_dataSize-1:0]   cap;
  logic                    unc_inc, cap_en;
  assign regWE    = hostWE | (state == WRITE);
  assign regWData = hostWE ? hostData : cap;
  assign busy     = state != IDLE;
  assign fatal    = state == FAIL;
  // next state; host write beats ack, ack beats timeout
  always_comb begin
    next    = state;
    unc_inc = 1'b0;
    cap_en  = 1'b0;
    case (state)
      IDLE: begin
        unc_inc = regUncorrErr & ~hostWE;
        next    = unc_inc ? REQ : IDLE;
      end
      REQ: begin
        cap_en = reloadAck & ~hostWE;
        next   = hostWE ? SETTLE : reloadAck ? WRITE :
                 (tcnt == TW'(p_reloadTimeout - 1)) ? FAIL : REQ;
      end
      WRITE: next = SETTLE;
      SETTLE: begin
        unc_inc = regUncorrErr;
        next    = regUncorrErr ? FAIL : IDLE;
      end
      default: next = FAIL;
    endcase
  end
  // state, request line, timeout and uncorrectable counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      reloadReq <= 1'b0;
      tcnt      <= '0;
      uncorrCnt <= '0;
    end else begin
      state     <= next;
      reloadReq <= next == REQ;
      tcnt      <= (state == REQ) ? tcnt + 1'b1 : '0;
      uncorrCnt <= clrCnt ? '0 : (unc_inc && !(&uncorrCnt)) ? uncorrCnt + 1'b1 : uncorrCnt;
    end
  end
  // hold the clean copy for the rewrite cycle
  always_ff @(posedge clk) begin
    if (cap_en) cap <= reloadData;
  end
`ifdef HAMMING_SCRUB_CORR_CNT_EN
  // saturating correctable count; flags are meaningless while the register is rewritten
  always_ff @(posedge clk) begin
    if (rst || clrCnt) corrCnt <= '0;
    else if (regCorrErr && state != WRITE && !(&corrCnt)) corrCnt <= corrCnt + 1'b1;
  end
`else
  logic unused_corr;
  assign unused_corr = regCorrErr;
  assign corrCnt     = '0;
`endif
endmodule
